// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// FSM state encoding, encoder select-bit positions and the step-count helper.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SEL_ONE = 0;
   localparam int SEL_TWO = 1;
   localparam int SEL_NEG = 2;

   // Two multiplier bits retire per step.
   function automatic int booth_steps(input int width);
      return width / 2;
   endfunction

endpackage

// File: rtl/booth_enc_r4.sv
// Radix-4 Booth digit encoder: {b[i+1], b[i], b[i-1]} -> {neg, two, one}.
// Purely combinational.
module booth_enc_r4
   import booth_pkg::*;
(
   input  logic [2:0] triplet_i,
   output logic [2:0] sel_o
);

   always_comb begin
      sel_o          = '0;
      sel_o[SEL_NEG] = triplet_i[2];
      sel_o[SEL_TWO] = (triplet_i == 3'b011) || (triplet_i == 3'b100);
      sel_o[SEL_ONE] = triplet_i[1] ^ triplet_i[0];
   end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier, WIDTH/2 steps per product.
// start/busy/done handshake; done pulses one cycle after the final step, product held until next start.
module booth_r4_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int NSTEP = booth_steps(WIDTH);
   localparam int CW    = $clog2(NSTEP + 1);
   localparam int HW    = WIDTH + 2;

   if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
      $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
   end

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [HW-1:0]        hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 q_q, q_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [2:0]           sel;
   logic [HW-1:0]        m_ext, m_dbl, pp_mag, pp, sum;
   logic [HW-1:0]        step_hi;
   logic [WIDTH-1:0]     step_lo;

   booth_enc_r4 u_enc (
      .triplet_i ({lo_q[1:0], q_q}),
      .sel_o     (sel)
   );

   // hi carries two guard bits so 2M and -2M never overflow the running sum.
   always_comb begin
      m_ext   = {{2{m_q[WIDTH-1]}}, m_q};
      m_dbl   = {m_q[WIDTH-1], m_q, 1'b0};
      pp_mag  = sel[SEL_TWO] ? m_dbl : (sel[SEL_ONE] ? m_ext : '0);
      pp      = sel[SEL_NEG] ? (~pp_mag + HW'(1)) : pp_mag;
      sum     = hi_q + pp;
      step_hi = {sum[HW-1], sum[HW-1], sum[HW-1:2]};
      step_lo = {sum[1:0], lo_q[WIDTH-1:2]};
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      m_d       = m_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      q_d       = q_q;
      product_d = product_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = RUN;
               cnt_d   = '0;
               m_d     = a;
               hi_d    = '0;
               lo_d    = b;
               q_d     = 1'b0;
            end
         end
         RUN: begin
            hi_d = step_hi;
            lo_d = step_lo;
            q_d  = lo_q[1];
            if (cnt_q == CW'(NSTEP - 1)) begin
               state_d   = DONE;
               product_d = {step_hi[WIDTH-1:0], step_lo};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         m_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         q_q       <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         m_q       <= m_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         q_q       <= q_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult at WIDTH=8 and WIDTH=16 plus exhaustive encoder check.
// Reference: plain signed multiply; Booth encoder reference derived from the digit value.
module tb_booth_r4_seq_mult;
   import booth_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] product8;

   logic        start16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16;
   logic [31:0] product16;

   logic [2:0]  trip = '0;
   logic [2:0]  sel_chk;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   booth_r4_seq_mult #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .product(product8)
   );

   booth_r4_seq_mult #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .product(product16)
   );

   booth_enc_r4 u_enc (
      .triplet_i(trip),
      .sel_o(sel_chk)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      return 16'(p);
   endfunction

   function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      return 32'(p);
   endfunction

   // Runs one WIDTH=8 operation from idle; checks latency, busy length, single done and result.
   task automatic op8(input logic [7:0] x, input logic [7:0] y, input string tag);
      int cycles;
      int busy_cnt;
      logic [15:0] exp;
      exp = ref8(x, y);
      @(negedge clk);
      start8 = 1'b1; a8 = x; b8 = y;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      cycles = 0; busy_cnt = 0;
      while (!done8 && cycles < 40) begin
         if (busy8) busy_cnt++;
         cycles++;
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom);
      end
      check({tag, "_lat"}, 64'(cycles), 64'd4);
      check({tag, "_busy"}, 64'(busy_cnt), 64'd4);
      check({tag, "_prod"}, 64'(product8), 64'(exp));
      @(negedge clk);
      check({tag, "_pulse"}, 64'(done8), 64'd0);
      check({tag, "_hold"}, 64'(product8), 64'(exp));
   endtask

   task automatic op16(input logic [15:0] x, input logic [15:0] y, input string tag);
      int cycles;
      logic [31:0] exp;
      exp = ref16(x, y);
      @(negedge clk);
      start16 = 1'b1; a16 = x; b16 = y;
      @(negedge clk);
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      cycles = 0;
      while (!done16 && cycles < 60) begin
         cycles++;
         @(negedge clk);
      end
      check({tag, "_lat"}, 64'(cycles), 64'd8);
      check({tag, "_prod"}, 64'(product16), 64'(exp));
   endtask

   initial begin
      logic [15:0] expq[$];
      int dn;
      int d;
      logic [2:0] exp_sel;

      // Encoder: digit = x1 + x0 - 2*x2.
      for (int t = 0; t < 8; t++) begin
         trip = 3'(t);
         #1;
         d = int'(trip[1]) + int'(trip[0]) - 2 * int'(trip[2]);
         exp_sel = '0;
         exp_sel[SEL_NEG] = trip[2];
         exp_sel[SEL_ONE] = (d == 1) || (d == -1);
         exp_sel[SEL_TWO] = (d == 2) || (d == -2);
         check($sformatf("enc_%0d", t), 64'(sel_chk), 64'(exp_sel));
      end

      #3;
      check("rst_busy", 64'(busy8), 64'd0);
      check("rst_done", 64'(done8), 64'd0);
      check("rst_prod", 64'(product8), 64'd0);
      check("rst_prod16", 64'(product16), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      op8(8'd3, 8'd5, "d_3x5");
      check("d_3x5_val", 64'(product8), 64'h000F);
      op8(8'hF9, 8'd6, "d_m7x6");
      check("d_m7x6_val", 64'(product8), 64'hFFD6);
      op8(8'd127, 8'h80, "d_127xm128");
      check("d_127xm128_val", 64'(product8), 64'hC080);
      op8(8'h80, 8'h80, "d_m128sq");
      check("d_m128sq_val", 64'(product8), 64'h4000);
      op8(8'd0, 8'hFF, "d_0xm1");
      check("d_0xm1_val", 64'(product8), 64'h0000);

      // start held high: acceptances only at IDLE and DONE, one every 5 edges.
      for (int i = 0; i < 20; i++) begin
         start8 = 1'b1;
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         if (i % 5 == 0) expq.push_back(ref8(a8, b8));
         @(negedge clk);
         check($sformatf("hold_done_%0d", i), 64'(done8), 64'(i % 5 == 4));
         if (i % 5 == 4 && expq.size() > 0) check("hold_prod", 64'(product8), 64'(expq.pop_front()));
      end
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);

      op8(8'd100, 8'd77, "pre_rst");
      // Asynchronous reset between edges during RUN.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd55; b8 = 8'd66;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 64'(busy8), 64'd0);
      check("arst_done", 64'(done8), 64'd0);
      check("arst_prod", 64'(product8), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done8) dn++;
      end
      check("arst_no_done", 64'(dn), 64'd0);
      op8(8'hC3, 8'd29, "post_rst");

      for (int i = 0; i < 40; i++) op8(8'($urandom), 8'($urandom), $sformatf("r8_%0d", i));
      op16(16'h8000, 16'h8000, "d16_min");
      op16(16'h7FFF, 16'h8000, "d16_mx");
      for (int i = 0; i < 25; i++) op16(16'($urandom), 16'($urandom), $sformatf("r16_%0d", i));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
